// File: rtl/piano_voice_allocator_if.sv
// Key-input and voice-output bundle between the key pins and the tone datapath.
// The allocator takes the slave side; whoever drives the keys takes the master side.
interface piano_voice_allocator_if #(
    parameter int NUM_KEYS   = 8,
    parameter int NUM_VOICES = 2
);
    localparam int KW = $clog2(NUM_KEYS);

    logic                       ena;
    logic                       tick_i;
    logic [NUM_KEYS-1:0]        keys_i;
    logic [NUM_VOICES-1:0]      voice_gate_o;
    logic [NUM_VOICES*KW-1:0]   voice_key_o;
    logic [NUM_VOICES-1:0]      voice_trig_o;
    logic                       busy_o;

    modport master (
        output ena, tick_i, keys_i,
        input  voice_gate_o, voice_key_o, voice_trig_o, busy_o
    );

    modport slave (
        input  ena, tick_i, keys_i,
        output voice_gate_o, voice_key_o, voice_trig_o, busy_o
    );
endinterface

// File: rtl/piano_voice_allocator.sv
// Debounces the piano keys and binds each new press to a voice: lowest free voice first,
// otherwise the least-recently-allocated one is stolen. One key is examined per cycle.
module piano_voice_allocator #(
    parameter int NUM_KEYS   = 8,
    parameter int NUM_VOICES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    piano_voice_allocator_if.slave  bus
);
    localparam int KW = $clog2(NUM_KEYS);
    localparam int RW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    logic [NUM_KEYS-1:0]    sync1;
    logic [NUM_KEYS-1:0]    ksync;
    logic [NUM_KEYS-1:0]    samp;
    logic [NUM_KEYS-1:0]    stable;
    logic [NUM_KEYS-1:0]    accepted;

    state_t                 state_q;
    state_t                 state_d;
    logic [KW-1:0]          idx;
    logic                   pending;
    logic                   busy;
    logic                   scan_act;
    logic                   last_key;
    logic                   tick_en;

    logic [NUM_VOICES-1:0]  gate;
    logic [NUM_VOICES-1:0]  trig;
    logic [KW-1:0]          vkey [NUM_VOICES];
    logic [RW-1:0]          rank [NUM_VOICES];

    logic                   any_free;
    logic [RW-1:0]          pick;
    logic [RW-1:0]          old_rank;
    logic [NUM_VOICES-1:0]  rel_hit;
    logic                   press;
    logic                   release_ev;

    assign tick_en  = bus.ena & bus.tick_i;
    assign last_key = (idx == KW'(NUM_KEYS - 1));

    // The synchroniser keeps running while disabled so re-enabling never sees stale metastable data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            ksync <= '0;
        end else begin
            sync1 <= bus.keys_i;
            ksync <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp   <= '0;
            stable <= '0;
        end else if (tick_en) begin
            samp   <= ksync;
            stable <= (~(ksync ^ samp) & ksync) | ((ksync ^ samp) & stable);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A tick or pending request on the last scan slot chains straight into the next scan.
    always_comb begin
        state_d = state_q;
        if (bus.ena) begin
            case (state_q)
                IDLE:    if (bus.tick_i || pending) state_d = SCAN;
                SCAN:    if (last_key && !(bus.tick_i || pending)) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state_q == SCAN);
        scan_act = (state_q == SCAN) && bus.ena;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            pending <= 1'b0;
        end else if (bus.ena) begin
            if (state_q == IDLE) begin
                idx     <= '0;
                pending <= 1'b0;
            end else begin
                idx <= idx + KW'(1);
                if (last_key) begin
                    pending <= 1'b0;
                end else if (bus.tick_i) begin
                    pending <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        press      = stable[idx] & ~accepted[idx];
        release_ev = ~stable[idx] & accepted[idx];
        any_free   = 1'b0;
        pick       = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!gate[v]) begin
                any_free = 1'b1;
                pick     = RW'(v);
            end
        end
        if (!any_free) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (rank[v] == '0) pick = RW'(v);
            end
        end
        old_rank = rank[pick];
        for (int v = 0; v < NUM_VOICES; v++) begin
            rel_hit[v] = gate[v] && (vkey[v] == idx);
        end
    end

    // Rank NUM_VOICES-1 is the newest allocation; everything younger than the reused voice ages by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accepted <= '0;
            gate     <= '0;
            trig     <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                vkey[v] <= '0;
                rank[v] <= RW'(v);
            end
        end else begin
            trig <= '0;
            if (scan_act) begin
                if (press) begin
                    accepted[idx] <= 1'b1;
                    gate[pick]    <= 1'b1;
                    vkey[pick]    <= idx;
                    trig[pick]    <= 1'b1;
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (RW'(v) == pick) begin
                            rank[v] <= RW'(NUM_VOICES - 1);
                        end else if (rank[v] > old_rank) begin
                            rank[v] <= rank[v] - RW'(1);
                        end
                    end
                end else if (release_ev) begin
                    accepted[idx] <= 1'b0;
                    gate          <= gate & ~rel_hit;
                end
            end
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_key_out
        assign bus.voice_key_o[v*KW +: KW] = vkey[v];
    end

    assign bus.voice_gate_o = gate;
    assign bus.voice_trig_o = trig & {NUM_VOICES{bus.ena}};
    assign bus.busy_o       = busy;
endmodule

// File: tb/tb_piano_voice_allocator.sv
// Directed scenarios for the voice allocator with hand-derived expected voice states.
module tb_piano_voice_allocator;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    logic [1:0] trig_log [32];
    logic       busy_log [32];

    piano_voice_allocator_if #(.NUM_KEYS(8), .NUM_VOICES(2)) bus ();

    piano_voice_allocator #(.NUM_KEYS(8), .NUM_VOICES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        bus.tick_i = 1'b0;
        bus.keys_i = '0;
        bus.ena    = 1'b1;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(2);
    endtask

    // Cycle 0 is the tick cycle; samples are taken at the falling edge of each cycle.
    task automatic tick_capture(input int ncyc, input int extra_at);
        for (int c = 0; c < ncyc; c++) begin
            bus.tick_i = (c == 0) || (c == extra_at);
            @(negedge clk);
            trig_log[c] = bus.voice_trig_o;
            busy_log[c] = bus.busy_o;
            @(posedge clk);
            #1;
        end
        bus.tick_i = 1'b0;
    endtask

    function automatic int count_trig(input int n);
        int cnt = 0;
        for (int i = 0; i < n; i++) if (trig_log[i] != 2'b00) cnt++;
        return cnt;
    endfunction

    function automatic int count_busy(input int lo, input int hi);
        int cnt = 0;
        for (int i = lo; i <= hi; i++) if (busy_log[i]) cnt++;
        return cnt;
    endfunction

    task automatic test_reset();
        @(posedge clk);
        #1;
        n_cmp++; if (bus.voice_gate_o !== 2'b00) begin n_bad++; $display("FAIL rst_gate: got %b want 00", bus.voice_gate_o); end
        n_cmp++; if (bus.voice_key_o !== 6'd0) begin n_bad++; $display("FAIL rst_key: got %h want 0", bus.voice_key_o); end
        n_cmp++; if (bus.voice_trig_o !== 2'b00) begin n_bad++; $display("FAIL rst_trig: got %b want 00", bus.voice_trig_o); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy_o); end
        rst_n = 1'b1;
        wait_cycles(3);
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL rst_idle_busy: got %b want 0", bus.busy_o); end
    endtask

    task automatic test_idle_scan();
        int trig_total = 0;
        do_reset();
        for (int t = 0; t < 4; t++) begin
            tick_capture(12, -1);
            trig_total += count_trig(12);
            n_cmp++; if (count_busy(0, 11) != 8) begin n_bad++; $display("FAIL idle_busy_len: got %0d want 8", count_busy(0, 11)); end
        end
        n_cmp++; if (busy_log[0] !== 1'b0 || busy_log[1] !== 1'b1 || busy_log[9] !== 1'b0) begin
            n_bad++; $display("FAIL idle_busy_window: got c0=%b c1=%b c9=%b want 0 1 0", busy_log[0], busy_log[1], busy_log[9]);
        end
        n_cmp++; if (bus.voice_gate_o !== 2'b00 || trig_total != 0) begin
            n_bad++; $display("FAIL idle_outputs: got gate=%b trigs=%0d want 00 0", bus.voice_gate_o, trig_total);
        end
    endtask

    task automatic test_single_press();
        do_reset();
        bus.keys_i = 8'h08;
        wait_cycles(3);
        tick_capture(12, -1);
        n_cmp++; if (bus.voice_gate_o !== 2'b00 || count_trig(12) != 0) begin
            n_bad++; $display("FAIL single_first_tick: got gate=%b trigs=%0d want 00 0", bus.voice_gate_o, count_trig(12));
        end
        tick_capture(12, -1);
        n_cmp++; if (trig_log[5] !== 2'b01) begin n_bad++; $display("FAIL single_trig_c5: got %b want 01", trig_log[5]); end
        n_cmp++; if (count_trig(12) != 1) begin n_bad++; $display("FAIL single_trig_cnt: got %0d want 1", count_trig(12)); end
        n_cmp++; if (bus.voice_gate_o !== 2'b01) begin n_bad++; $display("FAIL single_gate: got %b want 01", bus.voice_gate_o); end
        n_cmp++; if (bus.voice_key_o[2:0] !== 3'd3) begin n_bad++; $display("FAIL single_key0: got %0d want 3", bus.voice_key_o[2:0]); end
    endtask

    task automatic test_two_keys();
        do_reset();
        bus.keys_i = 8'h28;
        wait_cycles(3);
        tick_capture(12, -1);
        tick_capture(12, -1);
        n_cmp++; if (trig_log[5] !== 2'b01 || trig_log[7] !== 2'b10 || count_trig(12) != 2) begin
            n_bad++; $display("FAIL two_trig_seq: got c5=%b c7=%b cnt=%0d want 01 10 2", trig_log[5], trig_log[7], count_trig(12));
        end
        n_cmp++; if (bus.voice_gate_o !== 2'b11) begin n_bad++; $display("FAIL two_gate: got %b want 11", bus.voice_gate_o); end
        n_cmp++; if (bus.voice_key_o !== {3'd5, 3'd3}) begin n_bad++; $display("FAIL two_keys: got %o want 53", bus.voice_key_o); end
        bus.keys_i = 8'h20;
        wait_cycles(3);
        tick_capture(12, -1);
        tick_capture(12, -1);
        n_cmp++; if (bus.voice_gate_o !== 2'b10) begin n_bad++; $display("FAIL two_rel_gate: got %b want 10", bus.voice_gate_o); end
        n_cmp++; if (bus.voice_key_o[5:3] !== 3'd5) begin n_bad++; $display("FAIL two_rel_key1: got %0d want 5", bus.voice_key_o[5:3]); end
        n_cmp++; if (count_trig(12) != 0) begin n_bad++; $display("FAIL two_rel_trig: got %0d want 0", count_trig(12)); end
    endtask

    task automatic test_steal();
        do_reset();
        bus.keys_i = 8'h02;
        wait_cycles(3);
        tick_capture(12, -1);
        tick_capture(12, -1);
        bus.keys_i = 8'h06;
        wait_cycles(3);
        tick_capture(12, -1);
        tick_capture(12, -1);
        n_cmp++; if (bus.voice_key_o !== {3'd2, 3'd1}) begin n_bad++; $display("FAIL steal_pre_keys: got %o want 21", bus.voice_key_o); end
        bus.keys_i = 8'h46;
        wait_cycles(3);
        tick_capture(12, -1);
        tick_capture(12, -1);
        n_cmp++; if (trig_log[8] !== 2'b01 || count_trig(12) != 1) begin
            n_bad++; $display("FAIL steal_trig: got c8=%b cnt=%0d want 01 1", trig_log[8], count_trig(12));
        end
        n_cmp++; if (bus.voice_key_o !== {3'd2, 3'd6}) begin n_bad++; $display("FAIL steal_keys: got %o want 26", bus.voice_key_o); end
        n_cmp++; if (bus.voice_gate_o !== 2'b11) begin n_bad++; $display("FAIL steal_gate: got %b want 11", bus.voice_gate_o); end
        bus.keys_i = 8'h44;
        wait_cycles(3);
        tick_capture(12, -1);
        tick_capture(12, -1);
        n_cmp++; if (bus.voice_gate_o !== 2'b11 || bus.voice_key_o !== {3'd2, 3'd6} || count_trig(12) != 0) begin
            n_bad++; $display("FAIL steal_rel_stolen: got gate=%b keys=%o trigs=%0d want 11 26 0",
                              bus.voice_gate_o, bus.voice_key_o, count_trig(12));
        end
    endtask

    task automatic test_bounce();
        int trig_total = 0;
        do_reset();
        for (int t = 0; t < 6; t++) begin
            bus.keys_i = (t % 2 == 0) ? 8'h10 : 8'h00;
            wait_cycles(3);
            tick_capture(12, -1);
            trig_total += count_trig(12);
        end
        n_cmp++; if (bus.voice_gate_o !== 2'b00 || trig_total != 0) begin
            n_bad++; $display("FAIL bounce_quiet: got gate=%b trigs=%0d want 00 0", bus.voice_gate_o, trig_total);
        end
    endtask

    task automatic test_pending();
        do_reset();
        tick_capture(24, 3);
        n_cmp++; if (count_busy(1, 16) != 16) begin n_bad++; $display("FAIL pend_contig: got %0d want 16", count_busy(1, 16)); end
        n_cmp++; if (count_busy(0, 23) != 16) begin n_bad++; $display("FAIL pend_total: got %0d want 16", count_busy(0, 23)); end
        n_cmp++; if (busy_log[17] !== 1'b0) begin n_bad++; $display("FAIL pend_end: got %b want 0", busy_log[17]); end
    endtask

    task automatic test_ena_low();
        do_reset();
        bus.keys_i = 8'h01;
        wait_cycles(3);
        bus.ena = 1'b0;
        tick_capture(12, -1);
        tick_capture(12, -1);
        n_cmp++; if (count_busy(0, 11) != 0) begin n_bad++; $display("FAIL ena_no_scan: got %0d want 0", count_busy(0, 11)); end
        bus.ena = 1'b1;
        tick_capture(12, -1);
        n_cmp++; if (count_busy(0, 11) != 8) begin n_bad++; $display("FAIL ena_scan_after: got %0d want 8", count_busy(0, 11)); end
        n_cmp++; if (bus.voice_gate_o !== 2'b00 || count_trig(12) != 0) begin
            n_bad++; $display("FAIL ena_tick_ignored: got gate=%b trigs=%0d want 00 0", bus.voice_gate_o, count_trig(12));
        end
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        bus.keys_i = 8'h08;
        wait_cycles(3);
        tick_capture(12, -1);
        tick_capture(12, -1);
        bus.tick_i = 1'b1;
        wait_cycles(1);
        bus.tick_i = 1'b0;
        wait_cycles(4);
        n_cmp++; if (bus.busy_o !== 1'b1 || bus.voice_gate_o !== 2'b01) begin
            n_bad++; $display("FAIL mid_pre: got busy=%b gate=%b want 1 01", bus.busy_o, bus.voice_gate_o);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.voice_gate_o !== 2'b00 || bus.voice_key_o !== 6'd0 || bus.voice_trig_o !== 2'b00 || bus.busy_o !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset: got gate=%b key=%o trig=%b busy=%b want 00 0 00 0",
                              bus.voice_gate_o, bus.voice_key_o, bus.voice_trig_o, bus.busy_o);
        end
        bus.keys_i = 8'h60;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(3);
        tick_capture(12, -1);
        tick_capture(12, -1);
        bus.keys_i = 8'hE0;
        wait_cycles(3);
        tick_capture(12, -1);
        tick_capture(12, -1);
        n_cmp++; if (trig_log[9] !== 2'b01 || count_trig(12) != 1) begin
            n_bad++; $display("FAIL mid_steal_trig: got c9=%b cnt=%0d want 01 1", trig_log[9], count_trig(12));
        end
        n_cmp++; if (bus.voice_key_o !== {3'd6, 3'd7} || bus.voice_gate_o !== 2'b11) begin
            n_bad++; $display("FAIL mid_steal_state: got keys=%o gate=%b want 67 11", bus.voice_key_o, bus.voice_gate_o);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        bus.ena    = 1'b1;
        bus.tick_i = 1'b0;
        bus.keys_i = '0;
        test_reset();
        test_idle_scan();
        test_single_press();
        test_two_keys();
        test_steal();
        test_bounce();
        test_pending();
        test_ena_low();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
